magcmp_rgb: RTL
===============

Name: magcmp_rgb

Overview:
- Parametrised, sequential successor to the team's 2-bit RGB comparator.
- Accepts one operand pair through a valid/ready handshake and compares it bit-serially, MSB first, stopping at the first differing bit.
- Supports unsigned or two's-complement operands.
- Holds the last result and drives a PWM-dimmed RGB LED. Mapping: R = (a<=b), G = (a!=b), B = (a>=b).

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- PWM_BITS, 4, width of the brightness counter and of the duty input (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- signed_mode  input  1  1 = two's-complement compare; captured with operands.
- duty  input  PWM_BITS  LED brightness, sampled live.
- out_valid  output  1  one-cycle pulse: result flags just updated.
- lt  output  1  held result, a<b.
- eq  output  1  held result, a==b.
- gt  output  1  held result, a>b.
- R  output  1  PWM-gated (lt|eq).
- G  output  1  PWM-gated (lt|gt).
- B  output  1  PWM-gated (gt|eq).

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, lt=eq=gt=0, res_valid=0, pwm counter=0, R=G=B=0. Reset mid-scan aborts the compare with no out_valid, and the held result is cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture a, b, signed_mode; set idx=WIDTH-1; go to SCAN.
- SCAN:
  - in_ready=0; examine bit idx each cycle.
  - If a[idx]!=b[idx], decide.
    - Normal bit: gt=a[idx]. This also applies at idx=WIDTH-1 in unsigned mode.
    - idx=WIDTH-1 with signed_mode=1: gt=b[idx], i.e. a negative A is smaller.
    - Set lt=~gt, eq=0; go to DONE.
  - If the bits are equal and idx==0: eq=1, lt=gt=0; go to DONE.
  - Otherwise: idx-=1.
- DONE:
  - out_valid=1 for exactly one cycle; res_valid set to 1; go to IDLE.
- Latency: k = WIDTH-i, where i is the index of the most significant differing bit; k=WIDTH if the operands are equal. out_valid is high in the cycle after the k-th SCAN cycle, i.e. k+1 edges after the handshake edge. Throughput is one compare per k+2 cycles.
- Flags lt/eq/gt are registered and one-hot once res_valid=1. They change only on the SCAN decision edge and hold until the next decision or reset.
- in_valid while busy (SCAN/DONE) is ignored and not queued. Operands may change after the handshake without effect.
- PWM:
  - Free-running PWM_BITS counter that wraps at 2^PWM_BITS-1 -> 0.
  - on = (cnt < duty). duty=0 gives LED always off; duty=2^PWM_BITS-1 gives (2^PWM_BITS-1)/2^PWM_BITS on-time.
  - R/G/B are registered: colour term & on & res_valid. Output lags counter by one cycle; RGB are all 0 until the first result.

Decomposition:
- Package magcmp_pkg:
  - state enum (IDLE, SCAN, DONE);
  - packed struct cmp_res_t {lt, eq, gt};
  - function cmp_to_rgb(cmp_res_t) returning the 3-bit colour.
- Sub-module rgb_pwm:
  - inputs: clk, rst, duty, colour[2:0], enable;
  - outputs: R, G, B;
  - contains the counter and gating.
- magcmp_rgb holds the FSM and the operand registers.

Test Plan:
- Reset release, no input, duty=4'hF -> in_ready=1, lt=eq=gt=0, R=G=B=0 for 32 cycles.
- Unsigned a=8'h80, b=8'h7F -> out_valid 2 edges after handshake; gt=1; duty=4'hF gives G and B high 15 of 16 cycles, R=0.
- Same operands with signed_mode=1 -> same latency; lt=1; R and G gated, B=0.
- a=b=8'h5A -> out_valid 9 edges after handshake; eq=1; R and B gated, G=0. in_valid pulsed during SCAN with a=8'h00 is ignored and the result is unchanged.
- Duty sweep 0, 1, 8, 15 with result gt held -> G on-time 0, 1, 8, 15 of every 16 cycles; the change takes effect within one PWM period.
- rst asserted at the 3rd SCAN cycle of a=8'h01, b=8'h02 -> outputs clear immediately, no out_valid, in_ready=1 next cycle; a new compare then completes with lt=1 at k=7.

Source files
------------

// File: rtl/magcmp_pkg.sv
// magcmp_pkg: shared types and colour mapping for the bit-serial magnitude comparator
package magcmp_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_res_t;
    function automatic logic [2:0] cmp_to_rgb(cmp_res_t r);
        return {r.lt | r.eq, r.lt | r.gt, r.gt | r.eq};
    endfunction
endpackage

// File: rtl/rgb_pwm.sv
// rgb_pwm: free-running brightness counter gating a registered RGB colour
module rgb_pwm #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [2:0]          colour,
    input  logic                enable,
    output logic                R,
    output logic                G,
    output logic                B
);
    logic [PWM_BITS-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            {R, G, B} <= 3'b000;
        end else begin
            cnt       <= cnt + 1'b1;
            {R, G, B} <= colour & {3{enable && (cnt < duty)}};
        end
    end
endmodule

// File: rtl/magcmp_rgb.sv
// magcmp_rgb: MSB-first bit-serial signed/unsigned comparator driving a dimmed RGB LED
module magcmp_rgb
    import magcmp_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                signed_mode,
    input  logic [PWM_BITS-1:0] duty,
    output logic                out_valid,
    output logic                lt,
    output logic                eq,
    output logic                gt,
    output logic                R,
    output logic                G,
    output logic                B
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);
    state_t         state;
    logic [WIDTH-1:0] a_r, b_r;
    logic           sgn_r;
    logic [IW-1:0]  idx;
    cmp_res_t       res;
    logic           res_valid;
    logic           diff, gt_bit;
    assign diff = a_r[idx] ^ b_r[idx];
    // In signed mode the sign bit weighs negatively, so a set A sign means A is smaller
    assign gt_bit = (sgn_r && idx == TOP) ? b_r[idx] : a_r[idx];
    assign in_ready = state == IDLE;
    assign {lt, eq, gt} = res;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            sgn_r     <= 1'b0;
            idx       <= '0;
            res       <= '0;
            res_valid <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= a;
                    b_r   <= b;
                    sgn_r <= signed_mode;
                    idx   <= TOP;
                    state <= SCAN;
                end
                SCAN: if (diff) begin
                    res       <= '{lt: ~gt_bit, eq: 1'b0, gt: gt_bit};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end else if (idx == '0) begin
                    res       <= '{lt: 1'b0, eq: 1'b1, gt: 1'b0};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end else begin
                    idx <= idx - 1'b1;
                end
                DONE: begin
                    res_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    rgb_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .duty   (duty),
        .colour (cmp_to_rgb(res)),
        .enable (res_valid),
        .R      (R),
        .G      (G),
        .B      (B)
    );
endmodule
